ahbl_excl_sram: RTL and testbench

AHBL_EXCL_SRAM -- requirements
Module: ahbl_excl_sram

---
 rtl/ahbl_excl_sram.sv | 228 ++++++++++++++++++++++
 tb/tb_ahbl_excl_sram.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_excl_sram.sv
// ahbl_excl_sram: AHB-Lite SRAM slave with an optional wait-state data phase
// and an exclusive-access monitor that holds one reservation per master.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ahbls_hready             global bus ready (address phase qualifier)
//   ahbls_hready_resp        slave ready for the current data phase
//   ahbls_hresp              1 = ERROR response
//   ahbls_haddr/hwrite/htrans/hsize   address-phase controls
//   ahbls_hburst/hprot/hmastlock      accepted, not used
//   ahbls_hwdata, ahbls_hrdata        write / read data (full word)
//   ahbls_hexcl, ahbls_hmaster        exclusive request and master id
//   ahbls_hexokay            exclusive success, final data-phase cycle only
//
// State | meaning
// IDLE  | no data phase in progress
// WAIT  | data phase stalled, wait_cnt counts down the inserted wait cycles
// DONE  | final OKAY data-phase cycle; writes commit at its closing edge
// ERR1  | first ERROR cycle (hready_resp low)
// ERR2  | second ERROR cycle (hready_resp high)
module ahbl_excl_sram #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int N_MASTERS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,
    input  logic              ahbls_hexcl,
    input  logic [7:0]        ahbls_hmaster,
    output logic              ahbls_hexokay
);

    localparam int         W_IDX = $clog2(DEPTH);
    localparam logic [1:0] WS    = 2'(WAIT_STATES);
    localparam logic [7:0] N_MST = 8'(N_MASTERS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_nxt, st_open;
    logic [1:0] wait_cnt;

    logic [W_DATA-1:0] mem [DEPTH];

    // Address phase decode
    logic             accept, a_err, a_mst_ok, rd_accept, excl_set;
    logic [W_IDX-1:0] a_idx;
    logic [3:0]       a_lanes;
    logic [1:0]       a_mst;

    // Registered data-phase controls
    logic [W_IDX-1:0] d_idx;
    logic [3:0]       d_lanes;
    logic             d_write, d_excl, d_mst_ok;
    logic [1:0]       d_mst;

    // Exclusive monitor: entries at or above N_MASTERS are never set
    logic [3:0]       resv_vld;
    logic [W_IDX-1:0] resv_idx [4];
    logic             excl_match, commit;

    logic [W_DATA-1:0] rd_word;

    logic unused_ok;
    assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                         ahbls_htrans[0], ahbls_haddr};

    assign accept    = ahbls_hready & ahbls_htrans[1];
    assign a_idx     = ahbls_haddr[W_IDX+1:2];
    assign a_mst     = ahbls_hmaster[1:0];
    assign a_mst_ok  = ahbls_hmaster < N_MST;
    assign rd_accept = accept & ~a_err & ~ahbls_hwrite;
    assign excl_set  = rd_accept & ahbls_hexcl & a_mst_ok;

    always_comb begin
        a_err   = 1'b0;
        a_lanes = 4'b0000;
        case (ahbls_hsize)
            3'd0: a_lanes = 4'b0001 << ahbls_haddr[1:0];
            3'd1: begin
                a_lanes = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
                a_err   = ahbls_haddr[0];
            end
            3'd2: begin
                a_lanes = 4'b1111;
                a_err   = |ahbls_haddr[1:0];
            end
            default: a_err = 1'b1;
        endcase
    end

    // An exclusive write only lands if this master still holds the word.
    assign excl_match = d_excl & d_mst_ok & resv_vld[d_mst] &
                        (resv_idx[d_mst] == d_idx);
    assign commit     = (state == ST_DONE) & d_write & (~d_excl | excl_match);

    always_comb begin
        if (!accept)
            st_open = ST_IDLE;
        else if (a_err)
            st_open = ST_ERR1;
        else if (WS == 2'd0)
            st_open = ST_DONE;
        else
            st_open = ST_WAIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                wait_cnt <= WS;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt - 2'd1;
        end
    end

    always_comb begin
        state_nxt         = state;
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        ahbls_hexokay     = 1'b0;
        case (state)
            ST_IDLE: state_nxt = st_open;
            ST_WAIT: begin
                ahbls_hready_resp = 1'b0;
                if (wait_cnt == 2'd1)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ahbls_hexokay = d_excl & d_mst_ok & (~d_write | excl_match);
                state_nxt     = st_open;
            end
            ST_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
                state_nxt         = ST_ERR2;
            end
            ST_ERR2: begin
                ahbls_hresp = 1'b1;
                state_nxt   = st_open;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_idx    <= '0;
            d_lanes  <= '0;
            d_write  <= 1'b0;
            d_excl   <= 1'b0;
            d_mst_ok <= 1'b0;
            d_mst    <= '0;
        end else if (accept) begin
            d_idx    <= a_idx;
            d_lanes  <= a_lanes;
            d_write  <= ahbls_hwrite;
            d_excl   <= ahbls_hexcl;
            d_mst_ok <= a_mst_ok;
            d_mst    <= a_mst;
        end
    end

    // Clear on any committed write to the word; a set on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_vld <= '0;
            for (int i = 0; i < 4; i++)
                resv_idx[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (commit && resv_idx[i] == d_idx)
                    resv_vld[i] <= 1'b0;
            if (excl_set) begin
                resv_vld[a_mst] <= 1'b1;
                resv_idx[a_mst] <= a_idx;
            end
        end
    end

    // A read accepted on the edge a write to the same word commits sees the
    // merged word, not the stale array contents.
    always_comb begin
        rd_word = mem[a_idx];
        if (commit && d_idx == a_idx)
            for (int b = 0; b < 4; b++)
                if (d_lanes[b])
                    rd_word[8*b +: 8] = ahbls_hwdata[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ahbls_hrdata <= '0;
        else if (rd_accept)
            ahbls_hrdata <= rd_word;
    end

    always_ff @(posedge clk) begin
        if (commit)
            for (int b = 0; b < 4; b++)
                if (d_lanes[b])
                    mem[d_idx][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
    end

endmodule

// File: tb/tb_ahbl_excl_sram.sv
module tb_ahbl_excl_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans0 = 2'b00, htrans1 = 2'b00;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = '0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0;
    logic        hexcl = 1'b0;
    logic [7:0]  hmaster = '0;

    logic        rdy0, resp0, okay0, rdy1, resp1, okay1;
    logic [31:0] hrdata0, hrdata1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Zero-wait instance; each instance sees its own ready as global ready.
    ahbl_excl_sram #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .ahbls_hready(rdy0), .ahbls_hready_resp(rdy0),
        .ahbls_hresp(resp0), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans0), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hwdata(hwdata),
        .ahbls_hrdata(hrdata0), .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster),
        .ahbls_hexokay(okay0));

    ahbl_excl_sram #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .ahbls_hready(rdy1), .ahbls_hready_resp(rdy1),
        .ahbls_hresp(resp1), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans1), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hwdata(hwdata),
        .ahbls_hrdata(hrdata1), .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster),
        .ahbls_hexokay(okay1));

    typedef struct {
        logic        sel;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        excl;
        logic [7:0]  mst;
        int          nwait;
        logic        resp;
        logic        okay;
        logic        chk;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic excl, input logic [7:0] mst, input int nwait,
                       input logic resp, input logic okay, input logic chk,
                       input logic [31:0] rdata);
        vec_t v;
        v.sel = sel; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.excl = excl; v.mst = mst; v.nwait = nwait; v.resp = resp;
        v.okay = okay; v.chk = chk; v.rdata = rdata;
        vecs.push_back(v);
    endtask

    // One non-pipelined transfer; reports wait cycles, first and final
    // response, exokay and read data sampled in the final cycle.
    task automatic xfer(input logic sel, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic excl, input logic [7:0] mst,
                        output int nwait, output logic first_resp,
                        output logic fin_resp, output logic fin_okay,
                        output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        hwrite = wr; hsize = size; haddr = addr; hexcl = excl; hmaster = mst;
        if (sel) htrans1 = 2'b10; else htrans0 = 2'b10;
        @(posedge clk); #1;
        htrans0 = 2'b00; htrans1 = 2'b00; hexcl = 1'b0; hwdata = wdata;
        nwait = 0; got = 1'b0; first_resp = 1'b0;
        fin_resp = 1'b0; fin_okay = 1'b0; rdata = '0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (i == 0) first_resp = sel ? resp1 : resp0;
            if (sel ? rdy1 : rdy0) begin
                got = 1'b1;
                fin_resp = sel ? resp1 : resp0;
                fin_okay = sel ? okay1 : okay0;
                rdata    = sel ? hrdata1 : hrdata0;
            end else begin
                nwait++;
            end
        end
        check("xfer completed", 32'(got), 32'd1);
        @(posedge clk);
    endtask

    // Write immediately followed by a read on the zero-wait instance: the
    // write commits on the same edge the read is accepted.
    task automatic b2b(input logic [2:0] wsize, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic [7:0] wmst,
                       input logic [31:0] raddr, input logic rexcl,
                       input logic [7:0] rmst,
                       output logic [31:0] rdata, output logic rokay);
        @(negedge clk);
        hwrite = 1'b1; hsize = wsize; haddr = waddr; hexcl = 1'b0;
        hmaster = wmst; htrans0 = 2'b10;
        @(posedge clk); #1;
        hwdata = wdata; hwrite = 1'b0; hsize = 3'd2; haddr = raddr;
        hexcl = rexcl; hmaster = rmst; htrans0 = 2'b10;
        @(negedge clk);
        check("b2b write ready", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        htrans0 = 2'b00; hexcl = 1'b0;
        @(negedge clk);
        check("b2b read ready", 32'(rdy0), 32'd1);
        rdata = hrdata0;
        rokay = okay0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    int          nw;
    logic        fr, fresp, fok, rok;
    logic [31:0] rd;

    initial begin
        //   sel wr sz addr       wdata         ex mst nw rs ok chk rdata
        add(0, 1, 2, 32'h20, 32'h11223344, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h20, 32'h0,        0, 0, 0, 0, 0, 1, 32'h11223344);
        add(0, 1, 0, 32'h22, 32'h00BB0000, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h20, 32'h0,        0, 0, 0, 0, 0, 1, 32'h11BB3344);
        add(0, 1, 2, 32'h24, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 32'h26, 32'h12340000, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h24, 32'h0,        0, 0, 0, 0, 0, 1, 32'h1234F00D);
        add(0, 0, 2, 32'h42, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0);
        add(0, 0, 2, 32'h24, 32'h0,        0, 0, 0, 0, 0, 1, 32'h1234F00D);
        add(0, 0, 1, 32'h21, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0);
        add(0, 1, 3, 32'h20, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 32'h0);
        add(0, 1, 2, 32'h22, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 32'h0);
        add(0, 0, 2, 32'h20, 32'h0,        0, 0, 0, 0, 0, 1, 32'h11BB3344);
        add(0, 1, 0, 32'h23, 32'hFF000000, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h20, 32'h0,        0, 0, 0, 0, 0, 1, 32'hFFBB3344);
        // exclusive pair from master 0
        add(0, 1, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        1, 0, 0, 0, 1, 1, 32'h0);
        add(0, 1, 2, 32'h40, 32'h5,        1, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 1, 32'h5);
        add(0, 1, 2, 32'h40, 32'h7,        1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 1, 32'h5);
        // master 1 plain write breaks master 0's reservation
        add(0, 0, 2, 32'h40, 32'h0,        1, 0, 0, 0, 1, 1, 32'h5);
        add(0, 0, 2, 32'h40, 32'h0,        1, 1, 0, 0, 1, 1, 32'h5);
        add(0, 1, 2, 32'h40, 32'h99,       0, 1, 0, 0, 0, 0, 32'h0);
        add(0, 1, 2, 32'h40, 32'h77,       1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 1, 32'h99);
        // out-of-range masters touch nothing
        add(0, 0, 2, 32'h40, 32'h0,        1, 0, 0, 0, 1, 1, 32'h99);
        add(0, 1, 2, 32'h44, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h44, 32'h0,        1, 4, 0, 0, 0, 1, 32'hA5A5A5A5);
        add(0, 1, 2, 32'h40, 32'h55,       1, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 1, 32'h55);
        add(0, 1, 2, 32'h40, 32'h33,       1, 3, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h40, 32'h0,        0, 0, 0, 0, 0, 1, 32'h55);
        // reservation held on a different word
        add(0, 0, 2, 32'h40, 32'h0,        1, 1, 0, 0, 1, 1, 32'h55);
        add(0, 1, 2, 32'h44, 32'h66,       1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 2, 32'h44, 32'h0,        0, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
        // two wait states
        add(1, 1, 2, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0, 0, 0, 32'h0);
        add(1, 0, 2, 32'h10, 32'h0,        0, 0, 2, 0, 0, 1, 32'hDEADBEEF);
        add(1, 0, 2, 32'h12, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0);
        add(1, 0, 2, 32'h10, 32'h0,        0, 0, 2, 0, 0, 1, 32'hDEADBEEF);
        add(1, 1, 2, 32'h30, 32'h12345678, 0, 0, 2, 0, 0, 0, 32'h0);
        add(1, 0, 2, 32'h30, 32'h0,        1, 0, 2, 0, 1, 1, 32'h12345678);

        repeat (2) @(posedge clk);
        #1;
        check("reset ready0", 32'(rdy0), 32'd1);
        check("reset hresp0", 32'(resp0), 32'd0);
        check("reset exokay0", 32'(okay0), 32'd0);
        check("reset hrdata0", hrdata0, 32'h0);
        check("reset ready1", 32'(rdy1), 32'd1);
        check("reset hrdata1", hrdata1, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].sel, vecs[i].wr, vecs[i].size, vecs[i].addr,
                 vecs[i].wdata, vecs[i].excl, vecs[i].mst, nw, fr, fresp, fok, rd);
            check($sformatf("v%0d wait cycles", i), 32'(nw), 32'(vecs[i].nwait));
            check($sformatf("v%0d first hresp", i), 32'(fr), 32'(vecs[i].resp));
            check($sformatf("v%0d final hresp", i), 32'(fresp), 32'(vecs[i].resp));
            check($sformatf("v%0d hexokay", i), 32'(fok), 32'(vecs[i].okay));
            if (vecs[i].chk)
                check($sformatf("v%0d hrdata", i), rd, vecs[i].rdata);
        end

        // Byte write forwarded into the read accepted on its commit edge
        xfer(0, 1, 2, 32'h20, 32'h11223344, 0, 0, nw, fr, fresp, fok, rd);
        b2b(3'd0, 32'h21, 32'h0000AA00, 8'd0, 32'h20, 1'b0, 8'd0, rd, rok);
        check("fwd hrdata", rd, 32'h1122AA44);
        check("fwd hexokay", 32'(rok), 32'd0);
        xfer(0, 0, 2, 32'h20, 32'h0, 0, 0, nw, fr, fresp, fok, rd);
        check("fwd memory", rd, 32'h1122AA44);

        // Reservation set and clear on the same edge: the set survives
        xfer(0, 1, 2, 32'h48, 32'h0, 0, 0, nw, fr, fresp, fok, rd);
        xfer(0, 0, 2, 32'h48, 32'h0, 1, 0, nw, fr, fresp, fok, rd);
        check("setclr first exokay", 32'(fok), 32'd1);
        b2b(3'd2, 32'h48, 32'h1, 8'd1, 32'h48, 1'b1, 8'd0, rd, rok);
        check("setclr fwd hrdata", rd, 32'h1);
        check("setclr read exokay", 32'(rok), 32'd1);
        xfer(0, 1, 2, 32'h48, 32'h2, 1, 0, nw, fr, fresp, fok, rd);
        check("setclr write exokay", 32'(fok), 32'd1);
        xfer(0, 0, 2, 32'h48, 32'h0, 0, 0, nw, fr, fresp, fok, rd);
        check("setclr memory", rd, 32'h2);

        // Reset during the wait of a write on the two-wait instance
        @(negedge clk);
        hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30; hexcl = 1'b0;
        hmaster = 8'd0; htrans1 = 2'b10;
        @(posedge clk); #1;
        htrans1 = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst mid wait ready", 32'(rdy1), 32'd0);
        rst = 1'b1;
        #1;
        check("rst async ready", 32'(rdy1), 32'd1);
        check("rst async hresp", 32'(resp1), 32'd0);
        check("rst async exokay", 32'(okay1), 32'd0);
        check("rst async hrdata", hrdata1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(1, 0, 2, 32'h30, 32'h0, 0, 0, nw, fr, fresp, fok, rd);
        check("rst word kept", rd, 32'h12345678);
        xfer(1, 1, 2, 32'h30, 32'hAAAAAAAA, 1, 0, nw, fr, fresp, fok, rd);
        check("rst resv cleared exokay", 32'(fok), 32'd0);
        check("rst resv cleared hresp", 32'(fresp), 32'd0);
        xfer(1, 0, 2, 32'h30, 32'h0, 0, 0, nw, fr, fresp, fok, rd);
        check("rst excl write suppressed", rd, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
